// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg
//   Shared definitions for the common-data-bus arbiter: bus widths, source
//   indices, the invalid ROB tag and a small modular-increment helper.
//   No ports; imported by cdb_fifo, cdb_arbiter and the bench.
package cdb_arbiter_pkg;

  localparam int NickW = 5;
  localparam int DataW = 32;
  localparam int AddrW = 32;

  typedef logic [NickW-1:0] NickBus;
  typedef logic [DataW-1:0] DataBus;
  typedef logic [AddrW-1:0] AddrBus;

  localparam int CdbSrcAlu = 0;
  localparam int CdbSrcBr  = 1;
  localparam int CdbSrcLsb = 2;
  localparam int CdbSrcNum = 3;

  // ROB tag 0 never names a real entry.
  localparam int NullNick = 0;

  // (idx + 1) mod n without a divider; idx is always < n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// cdb_fifo
//   Small per-source result queue (circular buffer) feeding the CDB arbiter.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     i_clr         flush: empties the queue, wins over push/pop
//     i_push/i_din  write one entry (caller guarantees not full)
//     i_pop         drop the head entry (caller guarantees not empty)
//     o_head        current head entry (valid when o_count != 0)
//     o_count       number of stored entries, 0..DEPTH
module cdb_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 8,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic [W-1:0]  i_din,
  input  logic          i_pop,
  output logic [W-1:0]  o_head,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_cnt;

  // Storage needs no reset; only pointers and count define contents.
  always_ff @(posedge clk) begin
    if (i_push && !i_clr) r_mem[r_wr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= PW'(wrap_inc(int'(r_wr), DEPTH));
      if (i_pop)  r_rd <= PW'(wrap_inc(int'(r_rd), DEPTH));
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_cnt;

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Common-data-bus arbiter: each functional unit pushes results into its
//   own cdb_fifo; a round-robin scheduler grants one result per cycle onto
//   the registered CDB feeding the ROB result port and RS wakeup.
//   Optional build macro: CDB_BYPASS_EN -- an empty source may compete with
//   its live input and, if it wins, skip its queue (1-cycle latency).
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     rdy                   global enable, low freezes queues and grants
//     flush                 ROB misprediction clear, highest priority
//     src_valid/src_ready   per-source handshake
//     src_nick/dt/ac/j_pc   flattened per-source result fields
//     cdb_en..cdb_j_pc      registered broadcast
//     cdb_src               index of the granted source
//
//   Handshake: source i transfers a result at a clock edge exactly when
//   src_valid[i] && src_ready[i] is high in the cycle before it; src_ready
//   never depends on src_valid. A valid result carrying tag 0 is silently
//   discarded and changes no state.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = CdbSrcNum,
  parameter int DEPTH   = 2,
  parameter int NICK_W  = NickW,
  parameter int DATA_W  = DataW,
  parameter int ADDR_W  = AddrW,
  localparam int SW     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int PW     = NICK_W + DATA_W + 1 + ADDR_W,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic                        flush,
  input  logic [NUM_SRC-1:0]          src_valid,
  output logic [NUM_SRC-1:0]          src_ready,
  input  logic [NUM_SRC*NICK_W-1:0]   src_nick,
  input  logic [NUM_SRC*DATA_W-1:0]   src_dt,
  input  logic [NUM_SRC-1:0]          src_ac,
  input  logic [NUM_SRC*ADDR_W-1:0]   src_j_pc,
  output logic                        cdb_en,
  output logic [NICK_W-1:0]           cdb_nick,
  output logic [DATA_W-1:0]           cdb_dt,
  output logic                        cdb_ac,
  output logic [ADDR_W-1:0]           cdb_j_pc,
  output logic [SW-1:0]               cdb_src
);

`ifdef CDB_BYPASS_EN
  localparam bit BypassEn = 1'b1;
`else
  localparam bit BypassEn = 1'b0;
`endif

  logic [PW-1:0]      w_live  [NUM_SRC];
  logic [PW-1:0]      w_head  [NUM_SRC];
  logic [CW-1:0]      w_count [NUM_SRC];
  logic [NUM_SRC-1:0] w_acc;
  logic [NUM_SRC-1:0] w_cand;
  logic [NUM_SRC-1:0] w_push;
  logic [NUM_SRC-1:0] w_pop;

  logic               w_grant;
  logic               w_win_byp;
  logic [SW-1:0]      w_win;
  logic [PW-1:0]      w_sel;

  logic [SW-1:0]      r_last;
  logic               r_cdb_en;
  logic [NICK_W-1:0]  r_cdb_nick;
  logic [DATA_W-1:0]  r_cdb_dt;
  logic               r_cdb_ac;
  logic [ADDR_W-1:0]  r_cdb_j_pc;
  logic [SW-1:0]      r_cdb_src;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign w_live[g] = {src_nick[g*NICK_W +: NICK_W], src_dt[g*DATA_W +: DATA_W],
                        src_ac[g], src_j_pc[g*ADDR_W +: ADDR_W]};
    // Registered count: a full queue refuses even while it pops this cycle.
    assign src_ready[g] = rdy & ~rst & ~flush & (w_count[g] < CW'(DEPTH));
    assign w_acc[g]     = src_valid[g] & src_ready[g]
                        & (src_nick[g*NICK_W +: NICK_W] != NICK_W'(NullNick));
    // An empty queue may only compete through its live input when bypassing.
    assign w_cand[g]    = (w_count[g] != '0) | (BypassEn & w_acc[g]);
    assign w_pop[g]     = w_grant & (w_win == SW'(g)) & ~w_win_byp;
    assign w_push[g]    = w_acc[g] & ~(w_grant & w_win_byp & (w_win == SW'(g)));

    cdb_fifo #(
      .DEPTH (DEPTH),
      .W     (PW)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (flush),
      .i_push  (w_push[g]),
      .i_din   (w_live[g]),
      .i_pop   (w_pop[g]),
      .o_head  (w_head[g]),
      .o_count (w_count[g])
    );
  end

  // Round-robin search starting just after the last granted source.
  always_comb begin
    logic [SW-1:0] v_idx;
    w_grant   = 1'b0;
    w_win     = '0;
    w_win_byp = 1'b0;
    w_sel     = '0;
    v_idx     = r_last;
    for (int k = 0; k < NUM_SRC; k++) begin
      v_idx = SW'(wrap_inc(int'(v_idx), NUM_SRC));
      if (!w_grant && w_cand[v_idx]) begin
        w_grant   = 1'b1;
        w_win     = v_idx;
        w_win_byp = (w_count[v_idx] == '0);
        w_sel     = w_win_byp ? w_live[v_idx] : w_head[v_idx];
      end
    end
    // Frozen or flushing cycles never grant.
    if (!rdy || flush) begin
      w_grant   = 1'b0;
      w_win_byp = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last     <= SW'(NUM_SRC - 1);
      r_cdb_en   <= 1'b0;
      r_cdb_nick <= '0;
      r_cdb_dt   <= '0;
      r_cdb_ac   <= 1'b0;
      r_cdb_j_pc <= '0;
      r_cdb_src  <= '0;
    end else if (flush) begin
      r_last   <= SW'(NUM_SRC - 1);
      r_cdb_en <= 1'b0;
    end else if (w_grant) begin
      r_last   <= w_win;
      r_cdb_en <= 1'b1;
      {r_cdb_nick, r_cdb_dt, r_cdb_ac, r_cdb_j_pc} <= w_sel;
      r_cdb_src <= w_win;
    end else begin
      // Data fields hold; only the valid drops.
      r_cdb_en <= 1'b0;
    end
  end

  assign cdb_en   = r_cdb_en;
  assign cdb_nick = r_cdb_nick;
  assign cdb_dt   = r_cdb_dt;
  assign cdb_ac   = r_cdb_ac;
  assign cdb_j_pc = r_cdb_j_pc;
  assign cdb_src  = r_cdb_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
//   Self-checking bench for cdb_arbiter: directed scenarios followed by
//   random traffic, all checked against a queue-based reference model.
//   Honors CDB_BYPASS_EN in the model the same way the design does.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NS    = CdbSrcNum;
  localparam int DEPTH = 2;
  localparam int NW    = NickW;
  localparam int DW    = DataW;
  localparam int AW    = AddrW;
  localparam int PW    = NW + DW + 1 + AW;
`ifdef CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           rst;
  logic           rdy;
  logic           flush;
  logic [NS-1:0]  src_valid;
  logic [NS-1:0]  src_ready;
  logic [NS*NW-1:0] src_nick;
  logic [NS*DW-1:0] src_dt;
  logic [NS-1:0]  src_ac;
  logic [NS*AW-1:0] src_j_pc;
  logic           cdb_en;
  logic [NW-1:0]  cdb_nick;
  logic [DW-1:0]  cdb_dt;
  logic           cdb_ac;
  logic [AW-1:0]  cdb_j_pc;
  logic [1:0]     cdb_src;

  always #5 clk = ~clk;

  cdb_arbiter #(
    .NUM_SRC (NS),
    .DEPTH   (DEPTH),
    .NICK_W  (NW),
    .DATA_W  (DW),
    .ADDR_W  (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .flush     (flush),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_nick  (src_nick),
    .src_dt    (src_dt),
    .src_ac    (src_ac),
    .src_j_pc  (src_j_pc),
    .cdb_en    (cdb_en),
    .cdb_nick  (cdb_nick),
    .cdb_dt    (cdb_dt),
    .cdb_ac    (cdb_ac),
    .cdb_j_pc  (cdb_j_pc),
    .cdb_src   (cdb_src)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;

  // Per-source expected queue contents, packed {nick, dt, ac, j_pc}.
  logic [PW-1:0] exp_q [NS][$];
  int            m_last;
  logic          m_en;
  logic [PW-1:0] m_pay;
  int            m_src;

  // Next-cycle stimulus.
  logic [NS-1:0] d_valid;
  logic [NW-1:0] d_nick [NS];
  logic [DW-1:0] d_dt   [NS];
  logic          d_ac   [NS];
  logic [AW-1:0] d_jpc  [NS];
  logic          d_rdy;
  logic          d_flush;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_src(input logic [NS-1:0] v, input int n0, input int n1, input int n2);
    int n[NS];
    n[0] = n0; n[1] = n1; n[2] = n2;
    d_valid = v;
    for (int i = 0; i < NS; i++) begin
      d_nick[i] = NW'(n[i]);
      d_dt[i]   = $urandom;
      d_ac[i]   = 1'($urandom_range(0, 1));
      d_jpc[i]  = $urandom;
    end
    d_rdy   = 1'b1;
    d_flush = 1'b0;
  endtask

  task automatic set_idle();
    set_src('0, 0, 0, 0);
  endtask

  task automatic set_random();
    for (int i = 0; i < NS; i++) begin
      d_nick[i] = ($urandom_range(0, 7) == 0) ? '0 : NW'($urandom_range(1, 31));
      d_dt[i]   = $urandom;
      d_ac[i]   = 1'($urandom_range(0, 1));
      d_jpc[i]  = $urandom;
    end
    d_valid = NS'($urandom_range(0, 7));
    d_rdy   = ($urandom_range(0, 9) != 0);
    d_flush = ($urandom_range(0, 39) == 0);
  endtask

  // One cycle: check registered outputs, apply stimulus, advance the model.
  task automatic step();
    logic [NS-1:0] m_rdy;
    logic [NS-1:0] acc;
    logic [PW-1:0] live [NS];
    int            win;
    bit            byp;

    @(negedge clk);
    chk("cdb_en",   32'(cdb_en),   32'(m_en));
    chk("cdb_nick", 32'(cdb_nick), 32'(m_pay[PW-1 -: NW]));
    chk("cdb_dt",   cdb_dt,        m_pay[AW+1 +: DW]);
    chk("cdb_ac",   32'(cdb_ac),   32'(m_pay[AW]));
    chk("cdb_j_pc", cdb_j_pc,      m_pay[AW-1:0]);
    chk("cdb_src",  32'(cdb_src),  32'(m_src));

    rdy       = d_rdy;
    flush     = d_flush;
    src_valid = d_valid;
    for (int i = 0; i < NS; i++) begin
      src_nick[i*NW +: NW] = d_nick[i];
      src_dt[i*DW +: DW]   = d_dt[i];
      src_ac[i]            = d_ac[i];
      src_j_pc[i*AW +: AW] = d_jpc[i];
    end
    #1;

    for (int i = 0; i < NS; i++) begin
      live[i]  = {d_nick[i], d_dt[i], d_ac[i], d_jpc[i]};
      m_rdy[i] = d_rdy && !d_flush && (exp_q[i].size() < DEPTH);
      acc[i]   = d_valid[i] && m_rdy[i] && (d_nick[i] != '0);
    end
    chk("src_ready", 32'(src_ready), 32'(m_rdy));

    if (d_flush) begin
      for (int i = 0; i < NS; i++) exp_q[i].delete();
      m_last = NS - 1;
      m_en   = 1'b0;
    end else if (!d_rdy) begin
      m_en = 1'b0;
    end else begin
      win = -1;
      byp = 1'b0;
      for (int k = 1; k <= NS; k++) begin
        int s = (m_last + k) % NS;
        if (win < 0 && (exp_q[s].size() > 0 || (BYP && acc[s]))) win = s;
      end
      if (win >= 0) begin
        if (exp_q[win].size() > 0) begin
          m_pay = exp_q[win].pop_front();
        end else begin
          m_pay = live[win];
          byp   = 1'b1;
        end
        m_en   = 1'b1;
        m_src  = win;
        m_last = win;
      end else begin
        m_en = 1'b0;
      end
      for (int i = 0; i < NS; i++)
        if (acc[i] && !(byp && i == win)) exp_q[i].push_back(live[i]);
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    src_valid = '0; src_nick = '0; src_dt = '0; src_ac = '0; src_j_pc = '0;
    m_last = NS - 1; m_en = 1'b0; m_pay = '0; m_src = 0;
    set_idle();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cdb_en",   32'(cdb_en),    32'd0);
    chk("rst_cdb_nick", 32'(cdb_nick),  32'd0);
    chk("rst_cdb_dt",   cdb_dt,         32'd0);
    chk("rst_cdb_jpc",  cdb_j_pc,       32'd0);
    chk("rst_cdb_src",  32'(cdb_src),   32'd0);
    chk("rst_ready",    32'(src_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_ready",   32'(src_ready), 32'b111);

    // Idle after reset.
    run(2);

    // Single ALU push: nick 5, data 0x12345678.
    set_src(3'b001, 5, 0, 0);
    d_dt[CdbSrcAlu] = 32'h1234_5678;
    step();
    set_idle();
    run(4);

    // All three sources push every cycle with rotating nicks.
    for (int c = 0; c < 8; c++) begin
      set_src(3'b111, (3*c) % 31 + 1, (3*c+1) % 31 + 1, (3*c+2) % 31 + 1);
      step();
    end
    set_idle();
    run(8);

    // Fill the branch queue while ALU/LSB keep the CDB busy.
    for (int c = 0; c < 5; c++) begin
      set_src(3'b111, 10 + c, 20 + c, 25 + c);
      step();
    end
    set_idle();
    run(8);

    // Three queued results, then flush with a push in the flush cycle.
    set_src(3'b111, 7, 8, 9);
    step();
    set_src(3'b111, 11, 12, 13);
    d_flush = 1'b1;
    step();
    set_src(3'b010, 0, 14, 0);
    step();
    set_idle();
    run(4);

    // Two queued, rdy low for three cycles, then drain.
    set_src(3'b011, 3, 4, 0);
    step();
    for (int c = 0; c < 3; c++) begin
      set_idle();
      d_rdy = 1'b0;
      step();
    end
    set_idle();
    run(5);

    // Tag 0 is discarded.
    set_src(3'b111, 0, 0, 0);
    step();
    set_idle();
    run(3);

    // Random traffic.
    for (int c = 0; c < 2000; c++) begin
      set_random();
      step();
    end
    set_idle();
    run(10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
